// File: rtl/memory_arbiter.sv
// Serialises instruction-fetch and data load/store requests onto one variable-latency RAM port.
// Optional MEM_TIMEOUT_EN forces completion with 32'hBAD1BAD1 after TIMEOUT cycles in an access state.
module memory_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              ihit,
    output logic [DATA_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              dhit,
    output logic [DATA_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    output logic              busy,
    output logic              err
);

    typedef enum logic [1:0] {IDLE, DACC, IACC, RESP} state_t;

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    state_t            state;
    logic              last_d;
    logic              req_d;
    logic              grant_d;
    logic              ram_done;
    logic              done;
    logic              set_err;
    logic [DATA_W-1:0] word;

    assign req_d    = dREN | dWEN;
    assign grant_d  = req_d & ~(iREN & last_d);
    assign ram_done = (ramstate == RAM_ACCESS) || (ramstate == RAM_ERROR);

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt;
    logic             timed_out;

    // A real ACCESS/ERROR in the timeout cycle takes priority over the forced completion.
    assign timed_out = (cnt == CNT_W'(TIMEOUT)) && !ram_done;
    assign done      = ram_done || timed_out;
    assign set_err   = (ramstate == RAM_ERROR) || timed_out;
    assign word      = ramWEN ? '0 : (timed_out ? DATA_W'(32'hBAD1BAD1) : ramload);
`else
    assign done      = ram_done;
    assign set_err   = (ramstate == RAM_ERROR);
    assign word      = ramWEN ? '0 : ramload;
`endif

    // The RAM strobe/address registers double as the latched request, so they stay stable until completion.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            last_d   <= 1'b0;
            ihit     <= 1'b0;
            dhit     <= 1'b0;
            iload    <= '0;
            dload    <= '0;
            ramREN   <= 1'b0;
            ramWEN   <= 1'b0;
            ramaddr  <= '0;
            ramstore <= '0;
            busy     <= 1'b0;
            err      <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            cnt      <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_d || iREN) begin
                        busy     <= 1'b1;
                        last_d   <= grant_d;
                        ramaddr  <= grant_d ? daddr : iaddr;
                        ramREN   <= grant_d ? ~dWEN : 1'b1;
                        ramWEN   <= grant_d & dWEN;
                        ramstore <= (grant_d && dWEN) ? dstore : '0;
                        state    <= grant_d ? DACC : IACC;
`ifdef MEM_TIMEOUT_EN
                        cnt      <= '0;
`endif
                    end
                end
                DACC, IACC: begin
                    if (done) begin
                        state    <= RESP;
                        ramREN   <= 1'b0;
                        ramWEN   <= 1'b0;
                        ramaddr  <= '0;
                        ramstore <= '0;
                        if (state == DACC) begin
                            dhit  <= 1'b1;
                            dload <= word;
                        end else begin
                            ihit  <= 1'b1;
                            iload <= word;
                        end
                        if (set_err) begin
                            err <= 1'b1;
                        end
                    end
`ifdef MEM_TIMEOUT_EN
                    cnt <= cnt + 1'b1;
`endif
                end
                RESP: begin
                    ihit  <= 1'b0;
                    dhit  <= 1'b0;
                    iload <= '0;
                    dload <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
